packet_symbol_packer: RTL and testbench
=======================================

# packet_symbol_packer

- Avalon-ST narrow-to-wide packet adapter, the inverse of the team's wide-to-narrow symbol width adapter.
- Collects RATIO consecutive narrow input beats into one wide output word, first beat in the most-significant lane, and preserves packet framing.
- Short final words are zero-padded and flagged with an empty count.
- Sits between a narrow streaming source (DMA/serial front end) and wide-datapath processing logic.

## Interface
- INPUT_SYMBOL_WIDTH, 32, narrow input beat width in bits.
- OUTPUT_SYMBOL_WIDTH, 256, wide output word width; must be an integer multiple (RATIO = OUTPUT/INPUT, RATIO >= 2) of INPUT_SYMBOL_WIDTH.
- EMPTY_WIDTH, derived = max(1, $clog2(RATIO)), not user-overridable.
- clock_clk  in  1  single clock; all logic rising-edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- asi_in0_data  in  INPUT_SYMBOL_WIDTH  narrow beat.
- asi_in0_valid  in  1  beat valid.
- asi_in0_ready  out  1  beat accepted when valid && ready.
- asi_in0_startofpacket  in  1  first beat of packet.
- asi_in0_endofpacket  in  1  last beat of packet.
- aso_out0_data  out  OUTPUT_SYMBOL_WIDTH  packed word.
- aso_out0_valid  out  1  word valid.
- aso_out0_ready  in  1  sink accepts word when valid && ready.
- aso_out0_startofpacket  out  1  first word of packet.
- aso_out0_endofpacket  out  1  last word of packet.
- aso_out0_empty  out  EMPTY_WIDTH  unused narrow lanes in word (valid with endofpacket, else 0).

## Operation
- Internal state: accumulator (OUTPUT_SYMBOL_WIDTH), lane counter cnt (0..RATIO-1), in_packet flag, first_word flag, registered output stage (data/valid/sop/eop/empty).
- Lane mapping: beat k of a word (k = cnt at acceptance) lands in bits [OUTPUT_SYMBOL_WIDTH-1-k*INPUT_SYMBOL_WIDTH -: INPUT_SYMBOL_WIDTH].
- asi_in0_ready = reset_reset_n && (!aso_out0_valid || aso_out0_ready); combinational, independent of asi_in0_valid/sop/eop.
- IDLE (in_packet=0): accepted beats without sop are discarded. Accepted beat with sop: in_packet=1, first_word=1, beat written to lane 0, cnt=1.
- PACKING (in_packet=1): each accepted beat is written to lane cnt, cnt increments.
- Word completion occurs on an accepted beat when cnt==RATIO-1 or the beat has eop:
  - output stage loaded with the accumulator plus this beat;
  - unused lanes are 0;
  - sop = first_word;
  - eop = beat eop;
  - empty = eop ? RATIO-1-cnt : 0;
  - then cnt=0 and first_word=0.
- eop completion also clears in_packet (back to IDLE).
- sop while in_packet (protocol error): any partial word is discarded without output, the new beat becomes lane 0 of a new packet, and first_word=1. A previously completed word already in the output stage is not affected.
- Single-beat packet (sop && eop on one beat): one word with sop=1, eop=1, empty=RATIO-1.
- The accumulator clears to 0 on each completion, so padding lanes are always zero.
- Output stage holds all fields stable while valid && !ready. It drops valid on acceptance unless reloaded in the same cycle.

## Timing
- Reset (async assert, sync-safe release): aso_out0_valid/startofpacket/endofpacket=0, aso_out0_data=0, aso_out0_empty=0, accumulator=0, cnt=0, in_packet=0, first_word=0.
- asi_in0_ready is 0 while reset is asserted and 1 on the first cycle after release.
- Latency: the completing beat accepted at edge N produces aso_out0_valid=1 from edge N to edge N+1 onward.
- Throughput: one narrow beat per clock with the sink always ready. Back-to-back words are possible, including output accept and reload on the same edge.
- Backpressure: while aso_out0_valid && !aso_out0_ready, asi_in0_ready=0 and no beat is accepted (including non-completing beats).
- Reset asserted mid-packet: partial word and output stage are lost; the next packet needs a fresh sop.

## Test plan
- RATIO=8, sink always ready; sop packet of 16 beats data 0x00000001..0x00000010 -> two words:
  - word 1: 0x00000001 in bits[255:224] ... 0x00000008 in [31:0], sop=1, eop=0;
  - word 2: 0x00000009..0x00000010, sop=0, eop=1, empty=0;
  - each valid 1 cycle after the 8th beat.
- Packet of 11 beats -> word 2 holds beats 9..11 in the top three lanes, lower 160 bits zero, eop=1, empty=5.
- Single beat with sop+eop, data 0xDEADBEEF -> one word 0xDEADBEEF<<224, sop=1, eop=1, empty=7.
- Sink ready low for 5 cycles while a word is pending -> asi_in0_ready=0 for those cycles, aso_out0_data stable. After ready rises, the word is accepted and input resumes with no beat lost or duplicated.
- Beats without sop before a packet, then sop mid-word (cnt=3) -> pre-sop beats absent from output, the 3-beat partial is dropped, and the new packet's first word carries sop=1 with the new beat in the top lane.
- reset_reset_n pulsed low with cnt=4 and a word pending -> all outputs 0 immediately; after release, a fresh 8-beat packet yields a correct word with sop=1, eop=1, empty=0.

Source files
------------

// File: rtl/packet_symbol_packer.sv
// Avalon-ST narrow-to-wide packet adapter: packs RATIO narrow beats into one wide word,
// first beat in the top lane, with zero padding and an empty count on short final words.
module packet_symbol_packer #(
    parameter int INPUT_SYMBOL_WIDTH  = 32,
    parameter int OUTPUT_SYMBOL_WIDTH = 256,
    localparam int RATIO       = OUTPUT_SYMBOL_WIDTH / INPUT_SYMBOL_WIDTH,
    localparam int EMPTY_WIDTH = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1
) (
    input  logic                           clock_clk,
    input  logic                           reset_reset_n,
    input  logic [INPUT_SYMBOL_WIDTH-1:0]  asi_in0_data,
    input  logic                           asi_in0_valid,
    output logic                           asi_in0_ready,
    input  logic                           asi_in0_startofpacket,
    input  logic                           asi_in0_endofpacket,
    output logic [OUTPUT_SYMBOL_WIDTH-1:0] aso_out0_data,
    output logic                           aso_out0_valid,
    input  logic                           aso_out0_ready,
    output logic                           aso_out0_startofpacket,
    output logic                           aso_out0_endofpacket,
    output logic [EMPTY_WIDTH-1:0]         aso_out0_empty
);

    typedef enum logic {S_IDLE, S_PACKING} state_t;

    localparam logic [EMPTY_WIDTH-1:0] LAST_LANE = EMPTY_WIDTH'(RATIO - 1);

    state_t                         r_state;
    logic [EMPTY_WIDTH-1:0]         r_cnt;
    logic                           r_first;
    logic [OUTPUT_SYMBOL_WIDTH-1:0] r_acc;
    logic [OUTPUT_SYMBOL_WIDTH-1:0] r_out_data;
    logic                           r_out_valid;
    logic                           r_out_sop;
    logic                           r_out_eop;
    logic [EMPTY_WIDTH-1:0]         r_out_empty;

    logic                           w_in_ready;
    logic                           w_accept;
    logic                           w_keep;
    logic                           w_first;
    logic                           w_complete;
    logic [EMPTY_WIDTH-1:0]         w_idx;
    logic [EMPTY_WIDTH-1:0]         w_empty;
    logic [OUTPUT_SYMBOL_WIDTH-1:0] w_merged;

    // A sop beat always restarts at lane 0, discarding any partial word in flight.
    always_comb begin
        w_in_ready = reset_reset_n && (!r_out_valid || aso_out0_ready);
        w_accept   = asi_in0_valid && w_in_ready;
        w_keep     = asi_in0_startofpacket || (r_state == S_PACKING);
        w_idx      = asi_in0_startofpacket ? '0 : r_cnt;
        w_first    = asi_in0_startofpacket || r_first;
        w_merged   = asi_in0_startofpacket ? '0 : r_acc;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (EMPTY_WIDTH'(k) == w_idx)
                w_merged[OUTPUT_SYMBOL_WIDTH-1-k*INPUT_SYMBOL_WIDTH -: INPUT_SYMBOL_WIDTH] = asi_in0_data;
        end
        w_complete = (w_idx == LAST_LANE) || asi_in0_endofpacket;
        w_empty    = asi_in0_endofpacket ? (LAST_LANE - w_idx) : '0;
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
        end else begin
            if (r_out_valid && aso_out0_ready)
                r_out_valid <= 1'b0;
            if (w_accept && w_keep) begin
                if (w_complete) begin
                    r_out_data  <= w_merged;
                    r_out_valid <= 1'b1;
                    r_out_sop   <= w_first;
                    r_out_eop   <= asi_in0_endofpacket;
                    r_out_empty <= w_empty;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_first     <= 1'b0;
                    r_state     <= asi_in0_endofpacket ? S_IDLE : S_PACKING;
                end else begin
                    r_acc       <= w_merged;
                    r_cnt       <= w_idx + EMPTY_WIDTH'(1);
                    r_first     <= w_first;
                    r_state     <= S_PACKING;
                end
            end
        end
    end

    assign asi_in0_ready          = w_in_ready;
    assign aso_out0_data          = r_out_data;
    assign aso_out0_valid         = r_out_valid;
    assign aso_out0_startofpacket = r_out_sop;
    assign aso_out0_endofpacket   = r_out_eop;
    assign aso_out0_empty         = r_out_empty;

endmodule

// File: tb/tb_packet_symbol_packer.sv
// Bench for packet_symbol_packer: directed table, corner sequences and randomized
// traffic checked against a queue-based packet model.
module tb_packet_symbol_packer;

    localparam int IW = 32;
    localparam int OW = 256;
    localparam int R  = OW / IW;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid, in_ready, in_sop, in_eop;
    logic [OW-1:0] out_data;
    logic          out_valid, out_ready, out_sop, out_eop;
    logic [EW-1:0] out_empty;

    always #5 clk = ~clk;

    packet_symbol_packer #(.INPUT_SYMBOL_WIDTH(IW), .OUTPUT_SYMBOL_WIDTH(OW)) dut (
        .clock_clk(clk), .reset_reset_n(rst_n),
        .asi_in0_data(in_data), .asi_in0_valid(in_valid), .asi_in0_ready(in_ready),
        .asi_in0_startofpacket(in_sop), .asi_in0_endofpacket(in_eop),
        .aso_out0_data(out_data), .aso_out0_valid(out_valid), .aso_out0_ready(out_ready),
        .aso_out0_startofpacket(out_sop), .aso_out0_endofpacket(out_eop),
        .aso_out0_empty(out_empty)
    );

    typedef struct {
        logic [OW-1:0] d;
        bit            sop;
        bit            eop;
        logic [EW-1:0] empty;
    } exp_t;

    typedef struct {
        int len;
        int nwords;
        int last_empty;
    } vec_t;

    int            nchecks = 0;
    int            nerr = 0;
    exp_t          expq[$];
    logic [IW-1:0] m_beats[$];
    bit            m_in_pkt = 0;
    bit            m_first = 0;
    bit            last_in_acc;
    bit            prev_stall = 0;
    logic [OW+EW+1:0] held;
    int            words_seen = 0;
    int            stall_seen = 0;
    logic [OW-1:0] last_d;
    bit            last_sop, last_eop;
    logic [EW-1:0] last_empty;
    int            hold_low = 0;
    bit            rand_ready = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        expq.delete();
        m_beats.delete();
        m_in_pkt   = 0;
        m_first    = 0;
        prev_stall = 0;
    endtask

    task automatic model_beat(input logic [IW-1:0] d, input bit sop, input bit eop);
        exp_t e;
        if (sop) begin
            m_beats.delete();
            m_in_pkt = 1;
            m_first  = 1;
        end else if (!m_in_pkt) begin
            return;
        end
        m_beats.push_back(d);
        if (m_beats.size() == R || eop) begin
            e.d = '0;
            foreach (m_beats[i]) e.d[OW-1-i*IW -: IW] = m_beats[i];
            e.sop   = m_first;
            e.eop   = eop;
            e.empty = eop ? EW'(R - m_beats.size()) : '0;
            expq.push_back(e);
            m_beats.delete();
            m_first = 0;
            if (eop) m_in_pkt = 0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   exp_v;
        exp_v = (expq.size() != 0);
        check("out_valid", OW'(out_valid), OW'(exp_v));
        check("in_ready", OW'(in_ready), OW'(rst_n && (!exp_v || out_ready)));
        if (prev_stall)
            check("stall_hold", OW'({out_data, out_sop, out_eop, out_empty}), OW'(held));
        prev_stall = out_valid && !out_ready;
        held = {out_data, out_sop, out_eop, out_empty};
        if (prev_stall) stall_seen++;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_word", OW'(1), OW'(0));
            end else begin
                e = expq.pop_front();
                check("word_data", out_data, e.d);
                check("word_flags", OW'({out_sop, out_eop, out_empty}), OW'({e.sop, e.eop, e.empty}));
            end
            words_seen++;
            last_d = out_data; last_sop = out_sop; last_eop = out_eop; last_empty = out_empty;
        end
        last_in_acc = in_valid && in_ready;
        if (last_in_acc) model_beat(in_data, in_sop, in_eop);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (hold_low > 0) hold_low--;
        out_ready = (hold_low > 0) ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input bit sop, input bit eop);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
        do begin
            step();
            n++;
        end while (!last_in_acc && n < 100);
        if (!last_in_acc) check("beat_timeout", OW'(0), OW'(1));
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (expq.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", OW'(expq.size()), OW'(0));
        step();
    endtask

    task automatic send_packet(input int len, input logic [IW-1:0] base);
        for (int i = 0; i < len; i++)
            send_beat(base + IW'(i), i == 0, i == len - 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[6];
        int            w0, s0;
        logic [IW-1:0] d;
        logic [OW-1:0] dead;
        int            len;

        vecs[0] = '{16, 2, 0};
        vecs[1] = '{11, 2, 5};
        vecs[2] = '{1, 1, 7};
        vecs[3] = '{8, 1, 0};
        vecs[4] = '{9, 2, 7};
        vecs[5] = '{7, 1, 1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state", OW'({out_valid, out_sop, out_eop, out_empty, in_ready}), OW'(0));
        check("rst_data", out_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        foreach (vecs[v]) begin
            w0 = words_seen;
            send_packet(vecs[v].len, 32'h1);
            drain();
            check($sformatf("vec%0d_words", v), OW'(words_seen - w0), OW'(vecs[v].nwords));
            check($sformatf("vec%0d_empty", v), OW'(last_empty), OW'(vecs[v].last_empty));
            check($sformatf("vec%0d_eop", v), OW'(last_eop), OW'(1));
        end

        send_beat(32'hDEADBEEF, 1, 1);
        drain();
        dead = {32'hDEADBEEF, 224'h0};
        check("single_data", last_d, dead);
        check("single_flags", OW'({last_sop, last_eop, last_empty}), OW'({1'b1, 1'b1, 3'd7}));

        // Backpressure: word pending, sink low for 5 cycles while beat 9 waits.
        s0 = stall_seen; w0 = words_seen;
        for (int i = 0; i < 8; i++) send_beat(IW'(i + 1), i == 0, 1'b0);
        out_ready = 1'b0; hold_low = 5;
        for (int i = 8; i < 16; i++) send_beat(IW'(i + 1), 1'b0, i == 15);
        drain();
        check("bp_stalls", OW'(stall_seen - s0), OW'(5));
        check("bp_words", OW'(words_seen - w0), OW'(2));

        // Pre-sop garbage, then sop arriving with a 3-beat partial in flight.
        w0 = words_seen;
        send_beat(32'hBAD0_0001, 0, 0);
        send_beat(32'hBAD0_0002, 0, 1);
        for (int i = 0; i < 3; i++) send_beat(32'hA000_0000 + IW'(i), i == 0, 1'b0);
        for (int i = 0; i < 8; i++) send_beat(32'hC000_0000 + IW'(i), i == 0, i == 7);
        drain();
        check("sop_err_words", OW'(words_seen - w0), OW'(1));
        d = last_d[OW-1 -: IW];
        check("sop_err_top", OW'(d), OW'(32'hC000_0000));
        check("sop_err_flags", OW'({last_sop, last_eop, last_empty}), OW'({1'b1, 1'b1, 3'd0}));

        // Reset with a completed word pending in the output stage.
        for (int i = 0; i < 8; i++) send_beat(IW'(i + 100), i == 0, 1'b0);
        out_ready = 1'b0; hold_low = 1000;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("arst_state", OW'({out_valid, out_sop, out_eop, out_empty, in_ready}), OW'(0));
        check("arst_data", out_data, '0);
        model_clear();
        hold_low = 0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        w0 = words_seen;
        send_beat(32'h5555_5555, 0, 0);
        send_packet(8, 32'h7000_0000);
        drain();
        check("post_rst_words", OW'(words_seen - w0), OW'(1));
        d = last_d[OW-1 -: IW];
        check("post_rst_top", OW'(d), OW'(32'h7000_0000));
        check("post_rst_flags", OW'({last_sop, last_eop, last_empty}), OW'({1'b1, 1'b1, 3'd0}));

        // Randomized traffic with random sink readiness, gaps, garbage and aborted packets.
        rand_ready = 1;
        for (int p = 0; p < 150; p++) begin
            if ($urandom_range(0, 7) == 0) send_beat($urandom, 0, $urandom_range(0, 1) == 1);
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle();
                if (i > 0 && $urandom_range(0, 40) == 0) break;
                send_beat($urandom, i == 0, i == len - 1);
            end
        end
        rand_ready = 0; out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
